// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, state width, controller FSM encoding
// and the inverse-round transforms used by the decryption datapath.
// Bytes are numbered column-major: byte i sits at row i%4, column i/4,
// in bits [8*i +: 8] of an aes_state_t.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int STATE_W   = 128;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = STATE_W / BYTE_W;

  typedef logic [0:STATE_W-1] aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [7:0] get_byte(input aes_state_t s, input int idx);
    return s[BYTE_W*idx +: BYTE_W];
  endfunction

  // Row r rotates right by r columns.
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[BYTE_W*(4*c+row) +: BYTE_W] = get_byte(s, 4*((c - row + 4) % 4) + row);
      end
    end
    return r;
  endfunction

  function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
    aes_state_t r;
    r = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      r[BYTE_W*i +: BYTE_W] = inv_sbox(get_byte(s, i));
    end
    return r;
  endfunction

  function automatic aes_state_t add_round_key(input aes_state_t s, input aes_state_t k);
    return s ^ k;
  endfunction

  function automatic aes_state_t inv_mix_columns(input aes_state_t s);
    aes_state_t r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(s, 4*c+0);
      a1 = get_byte(s, 4*c+1);
      a2 = get_byte(s, 4*c+2);
      a3 = get_byte(s, 4*c+3);
      r[BYTE_W*(4*c+0) +: BYTE_W] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      r[BYTE_W*(4*c+1) +: BYTE_W] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      r[BYTE_W*(4*c+2) +: BYTE_W] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      r[BYTE_W*(4*c+3) +: BYTE_W] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational single AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
// last_round skips InvMixColumns for the final (round 0) step.
module aes_inv_round
  import aes_pkg::*;
(
  input  aes_state_t state_in,
  input  aes_state_t round_key,
  input  logic       last_round,
  output aes_state_t state_out
);

  aes_state_t sub_out;
  aes_state_t key_out;

  assign sub_out   = inv_sub_bytes(inv_shift_rows(state_in));
  assign key_out   = add_round_key(sub_out, round_key);
  assign state_out = last_round ? key_out : inv_mix_columns(key_out);

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption controller. One inverse round per clock,
// round keys fetched by index from an external key-schedule store whose
// read is combinational. Plaintext is held in DONE until the sink takes it.
// Optional feature macro: AES_DEC_ABORT_EN adds an 'abort' input that drops
// the block in flight (ROUND, FINAL or DONE) and returns to IDLE.
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR       = AES_NR,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
`ifdef AES_DEC_ABORT_EN
  input  logic                abort,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [0:127]        in_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [0:127]        rk_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [0:127]        out_data,
  output logic                busy
);

  localparam logic [RK_IDX_W-1:0] LAST_IDX  = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] FIRST_RND = RK_IDX_W'(NR - 1);
  localparam logic [RK_IDX_W-1:0] ONE_IDX   = RK_IDX_W'(1);

  ctrl_state_e         state;
  ctrl_state_e         next_state;
  aes_state_t          state_reg;
  aes_state_t          round_out;
  logic [RK_IDX_W-1:0] round_cnt;
  logic                accept;
  logic                cancel;
  logic                last_round;

`ifdef AES_DEC_ABORT_EN
  assign cancel = abort && (state != IDLE);
`else
  assign cancel = 1'b0;
`endif

  assign last_round = (state == FINAL);

  aes_inv_round u_round (
    .state_in  (state_reg),
    .round_key (rk_data),
    .last_round(last_round),
    .state_out (round_out)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic plus handshake and key-index decode
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    rk_idx     = LAST_IDX;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept     = 1'b1;
          next_state = ROUND;
        end
      end
      ROUND: begin
        rk_idx = round_cnt;
        if (round_cnt <= ONE_IDX) next_state = FINAL;
      end
      FINAL: begin
        rk_idx     = '0;
        next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (cancel) next_state = IDLE;
  end

  // Datapath: state register, round counter and registered plaintext
  always_ff @(posedge clk) begin
    if (rst || cancel) begin
      state_reg <= '0;
      round_cnt <= LAST_IDX;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_data <= '0;
          if (accept) begin
            state_reg <= in_data ^ rk_data;
            round_cnt <= FIRST_RND;
          end else begin
            round_cnt <= LAST_IDX;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          round_cnt <= round_cnt - ONE_IDX;
        end
        FINAL: begin
          state_reg <= round_out;
          out_data  <= round_out;
        end
        DONE: begin
          if (out_ready) out_data <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Testbench for aes_inv_round_ctrl: known-answer vectors, rk_idx trace,
// backpressure, held in_valid, mid-block reset, throughput, optional abort,
// and random blocks checked against a behavioural AES decryption model.
module tb_aes_inv_round_ctrl;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_data;
  logic [3:0]   rk_idx;
  logic [0:127] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_data;
  logic         busy;
`ifdef AES_DEC_ABORT_EN
  logic         abort;
`endif

  logic [0:127] rk_store [0:15];
  logic [0:127] ref_rk   [0:NR];
  logic [7:0]   sbox_t     [0:255];
  logic [7:0]   inv_sbox_t [0:255];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [0:127] key;
    logic [0:127] ct;
    logic [0:127] pt;
    int           bp;
    bit           hold;
  } vec_t;

  vec_t vecs [3];

  always #5 clk = ~clk;

  assign rk_data = rk_store[rk_idx];

  aes_inv_round_ctrl #(.NR(NR), .RK_IDX_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef AES_DEC_ABORT_EN
    .abort    (abort),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .rk_idx   (rk_idx),
    .rk_data  (rk_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // Forward S-box from a brute-force inverse search; inverse S-box by table inversion
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x]     = s;
      inv_sbox_t[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [0:127] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int i = 0; i < 16; i++) rk_store[i] = (i <= NR) ? ref_rk[i] : '0;
  endtask

  function automatic logic [0:127] ref_decrypt(input logic [0:127] ct);
    logic [7:0]   st  [4][4];
    logic [7:0]   tmp [4][4];
    logic [7:0]   col [4];
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [0:127] key_r;
    logic [0:127] res;
    base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    key_r = ref_rk[NR];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[r][c] = ct[8*(4*c+r) +: 8] ^ key_r[8*(4*c+r) +: 8];
    for (int rnd = NR - 1; rnd >= 0; rnd--) begin
      key_r = ref_rk[rnd];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) tmp[r][(c + r) % 4] = st[r][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) st[r][c] = inv_sbox_t[tmp[r][c]] ^ key_r[8*(4*c+r) +: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int k = 0; k < 4; k++) col[k] = st[k][c];
          for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(base[(k - r + 4) % 4], col[k]);
            st[r][c] = acc;
          end
        end
      end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[8*(4*c+r) +: 8] = st[r][c];
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Load key schedule, offer ciphertext for one edge; returns in cycle 1 of the block
  task automatic applyStimulus(input logic [0:127] key, input logic [0:127] ct, input bit hold);
    expand_key(key);
    checkOutput("accept_in_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_data  = ct;
    tick();
    in_valid = hold;
    in_data  = rand128();
  endtask

  task automatic run_block(input logic [0:127] key, input logic [0:127] ct,
                           input logic [0:127] pt, input int bp, input bit hold);
    applyStimulus(key, ct, hold);
    for (int k = 1; k <= 10; k++) begin
      checkOutput("rk_idx_trace", 128'(rk_idx), 128'((k <= 9) ? (10 - k) : 0));
      checkOutput("busy_ready_valid", 128'({busy, in_ready, out_valid}), 128'(3'b100));
      in_data = rand128();
      tick();
    end
    checkOutput("out_valid_at_11", 128'(out_valid), 128'(1));
    checkOutput("plaintext", out_data, pt);
    checkOutput("done_in_ready", 128'(in_ready), 128'(0));
    for (int i = 0; i < bp; i++) begin
      tick();
      checkOutput("bp_out_valid", 128'(out_valid), 128'(1));
      checkOutput("bp_out_data", out_data, pt);
      checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("idle_ready_valid_busy", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    checkOutput("idle_out_data", out_data, 128'(0));
    checkOutput("idle_rk_idx", 128'(rk_idx), 128'(NR));
  endtask

  task automatic watch_no_output(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    checkOutput(name, 128'(seen), 128'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc_q[$];
    int ov_q[$];
    logic [0:127] key, ct, pt;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff, 20, 1'b1};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734, 0, 1'b0};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a, 2, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef AES_DEC_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < 16; i++) rk_store[i] = '0;
    build_tables();

    tick(); tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_in_ready", 128'(in_ready), 128'(1));
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_out_data", out_data, 128'(0));
    checkOutput("reset_rk_idx", 128'(rk_idx), 128'(NR));

    $display("[TB] known-answer vectors");
    for (int v = 0; v < 3; v++) run_block(vecs[v].key, vecs[v].ct, vecs[v].pt, vecs[v].bp, vecs[v].hold);

    $display("[TB] reset in cycle 5 of a block");
    applyStimulus(vecs[0].key, vecs[0].ct, 1'b0);
    for (int i = 1; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_ready_valid_busy", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    checkOutput("rst_mid_rk_idx", 128'(rk_idx), 128'(NR));
    watch_no_output("rst_mid_no_output", 14);
    run_block(vecs[0].key, vecs[0].ct, vecs[0].pt, 0, 1'b0);

`ifdef AES_DEC_ABORT_EN
    $display("[TB] abort in cycle 4 of a block");
    abort = 1'b1;
    applyStimulus(vecs[1].key, vecs[1].ct, 1'b0);
    abort = 1'b0;
    checkOutput("abort_idle_no_effect", 128'(busy), 128'(1));
    for (int i = 1; i < 4; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_ready_valid_busy", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    watch_no_output("abort_no_output", 14);
    run_block(vecs[1].key, vecs[1].ct, vecs[1].pt, 1, 1'b0);
`endif

    $display("[TB] throughput with out_ready held high");
    expand_key(vecs[0].key);
    in_valid  = 1'b1;
    in_data   = vecs[0].ct;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (in_ready) acc_q.push_back(cyc);
      if (out_valid) begin
        ov_q.push_back(cyc);
        checkOutput("tput_data", out_data, vecs[0].pt);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    out_ready = 1'b0;
    checkOutput("tput_accept_count", 128'(acc_q.size()), 128'(3));
    checkOutput("tput_out_count", 128'(ov_q.size()), 128'(2));
    if (acc_q.size() >= 2 && ov_q.size() >= 1) begin
      checkOutput("tput_gap", 128'(acc_q[1] - acc_q[0]), 128'(12));
      checkOutput("tput_latency", 128'(ov_q[0] - acc_q[0]), 128'(11));
    end
    checkOutput("tput_drained_idle", 128'(in_ready), 128'(1));

    $display("[TB] random blocks against reference model");
    for (int n = 0; n < 8; n++) begin
      key = rand128();
      ct  = rand128();
      expand_key(key);
      pt  = ref_decrypt(ct);
      run_block(key, ct, pt, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
